// File: rtl/sfx_sequencer.sv
// Pong sound-effect sequencer: two-phase on/off patterns with a per-effect tone.
// Optional pre-emption by higher effect codes when SFX_PREEMPT_EN is defined.
module sfx_sequencer #(
  parameter int unsigned CLK_FREQ_HZ = 16000000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned TIME_W      = 4,
  parameter int unsigned REP_W       = 4,
  parameter int unsigned TONE_HALF_1 = 32,
  parameter int unsigned TONE_HALF_2 = 16,
  parameter int unsigned TONE_HALF_3 = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] snd_sel,
  input  logic       mute,
  output logic       snd_ack,
  output logic       busy,
  output logic [1:0] cur_snd,
  output logic       audio_o
);

  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned TH_12 =
    (TONE_HALF_1 > TONE_HALF_2) ? TONE_HALF_1 : TONE_HALF_2;
  localparam int unsigned TH_MAX =
    (TH_12 > TONE_HALF_3) ? TH_12 : TONE_HALF_3;
  localparam int unsigned TONE_W =
    (TH_MAX < 2) ? 1 : $clog2(TH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_A_ON, S_A_OFF, S_B_ON, S_B_OFF
  } state_e;

  typedef enum logic [2:0] {
    P_AON, P_AOFF, P_AEND, P_BON, P_BOFF, P_BEND, P_DONE
  } pt_e;

  state_e state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [TIME_W-1:0] seg_q, seg_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [1:0]        cur_q, cur_d;
  logic [TONE_W-1:0] tcnt_q, tcnt_d;
  logic              lvl_q, lvl_d;
  logic              busy_q, busy_d;
  logic              accept_q, accept_d;
  logic              ack_q;
  logic              audio_q, audio_d;

  logic tick, tick_end, go, done, start_seg, on_d;
  pt_e  pt;
  logic [REP_W-1:0]  rem;
  logic [TIME_W-1:0] a_on, a_off, b_on, b_off;
  logic [REP_W-1:0]  a_reps, b_reps;
  logic [TONE_W-1:0] half;

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));
  assign div_d = tick ? '0 : div_q + DIV_W'(1);
  assign tick_end = tick && (seg_q <= TIME_W'(1));

  always_comb begin
    a_on = '0; a_off = '0; a_reps = '0;
    b_on = '0; b_off = '0; b_reps = '0;
    case (cur_q)
      2'd1: begin
        a_on = TIME_W'(3); a_off = TIME_W'(1); a_reps = REP_W'(10);
        b_on = TIME_W'(1); b_off = TIME_W'(10); b_reps = REP_W'(2);
      end
      2'd2: begin
        a_on = TIME_W'(3); a_off = TIME_W'(1); a_reps = REP_W'(10);
      end
      2'd3: begin
        a_on = TIME_W'(2); a_off = TIME_W'(2); a_reps = REP_W'(4);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    rep_d     = rep_q;
    cur_d     = cur_q;
    accept_d  = 1'b0;
    go        = 1'b0;
    done      = 1'b0;
    start_seg = 1'b0;
    pt        = P_DONE;
    rem       = rep_q;

    case (state_q)
      S_IDLE: if (snd_sel != 2'd0) begin
        state_d  = S_WAIT;
        cur_d    = snd_sel;
        accept_d = 1'b1;
      end
      S_WAIT: if (tick) begin
        go = 1'b1; pt = P_AON; rem = a_reps;
      end
      S_A_ON: if (tick_end) begin
        go = 1'b1; pt = P_AOFF;
      end else if (tick) seg_d = seg_q - TIME_W'(1);
      S_A_OFF: if (tick_end) begin
        go = 1'b1; pt = P_AEND;
      end else if (tick) seg_d = seg_q - TIME_W'(1);
      S_B_ON: if (tick_end) begin
        go = 1'b1; pt = P_BOFF;
      end else if (tick) seg_d = seg_q - TIME_W'(1);
      S_B_OFF: if (tick_end) begin
        go = 1'b1; pt = P_BEND;
      end else if (tick) seg_d = seg_q - TIME_W'(1);
      default: state_d = S_IDLE;
    endcase

    // Walk past zero-length segments and empty phases within one cycle
    if (go) begin
      for (int i = 0; i < 8; i++) begin
        if (!done) begin
          case (pt)
            P_AON:
              if (rem == '0 || (a_on == '0 && a_off == '0)) begin
                pt = P_BON; rem = b_reps;
              end else if (a_on != '0) begin
                state_d = S_A_ON; seg_d = a_on; done = 1'b1;
              end else pt = P_AOFF;
            P_AOFF:
              if (a_off != '0) begin
                state_d = S_A_OFF; seg_d = a_off; done = 1'b1;
              end else pt = P_AEND;
            P_AEND: begin
              if (rem != '0) rem = rem - REP_W'(1);
              if (rem != '0) pt = P_AON;
              else begin
                pt = P_BON; rem = b_reps;
              end
            end
            P_BON:
              if (rem == '0 || (b_on == '0 && b_off == '0)) pt = P_DONE;
              else if (b_on != '0) begin
                state_d = S_B_ON; seg_d = b_on; done = 1'b1;
              end else pt = P_BOFF;
            P_BOFF:
              if (b_off != '0) begin
                state_d = S_B_OFF; seg_d = b_off; done = 1'b1;
              end else pt = P_BEND;
            P_BEND: begin
              if (rem != '0) rem = rem - REP_W'(1);
              pt = (rem != '0) ? P_BON : P_DONE;
            end
            default: begin
              state_d = S_IDLE; cur_d = 2'd0;
              seg_d = '0; rem = '0; done = 1'b1;
            end
          endcase
        end
      end
      if (!done) begin
        state_d = S_IDLE; cur_d = 2'd0; seg_d = '0; rem = '0;
      end
      rep_d     = rem;
      start_seg = (state_d != S_IDLE);
    end

`ifdef SFX_PREEMPT_EN
    if (state_q != S_IDLE && snd_sel > cur_q) begin
      state_d   = S_WAIT;
      cur_d     = snd_sel;
      accept_d  = 1'b1;
      start_seg = 1'b0;
      seg_d     = '0;
      rep_d     = '0;
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    half = '0;
    case (cur_d)
      2'd1: half = TONE_W'(TONE_HALF_1);
      2'd2: half = TONE_W'(TONE_HALF_2);
      2'd3: half = TONE_W'(TONE_HALF_3);
      default: ;
    endcase
    on_d   = (state_d == S_A_ON) || (state_d == S_B_ON);
    lvl_d  = lvl_q;
    tcnt_d = tcnt_q;
    if (!on_d) begin
      lvl_d = 1'b0; tcnt_d = '0;
    end else if (start_seg) begin
      lvl_d = 1'b1; tcnt_d = '0;
    end else if (half == '0) begin
      lvl_d = 1'b1;
    end else if (tcnt_q == half - TONE_W'(1)) begin
      lvl_d = ~lvl_q; tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TONE_W'(1);
    end
    // Mute gates only the pin so the tone keeps its phase
    audio_d = lvl_d & ~mute;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      seg_q    <= '0;
      rep_q    <= '0;
      cur_q    <= 2'd0;
      tcnt_q   <= '0;
      lvl_q    <= 1'b0;
      busy_q   <= 1'b0;
      accept_q <= 1'b0;
      ack_q    <= 1'b0;
      audio_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      seg_q    <= seg_d;
      rep_q    <= rep_d;
      cur_q    <= cur_d;
      tcnt_q   <= tcnt_d;
      lvl_q    <= lvl_d;
      busy_q   <= busy_d;
      accept_q <= accept_d;
      ack_q    <= accept_q;
      audio_q  <= audio_d;
    end
  end

  assign snd_ack = ack_q;
  assign busy    = busy_q;
  assign cur_snd = cur_q;
  assign audio_o = audio_q;

endmodule
